als_monitor: RTL and testbench
==============================

Name: als_monitor

Overview:
- Periodic sampler and classifier for the ambient-light sensor front end; sits directly downstream of the ALS SPI reader (fetch/ready/illum handshake).
- Requests a reading every SAMPLE_PERIOD clocks and block-averages 2^AVG_LOG2 readings.
- Classifies the average against dark/light thresholds with hysteresis and feeds the alarm logic with a level, a dark flag and a change pulse.

Parameters:
- SAMPLE_PERIOD, 100000, clocks between fetch requests (>= 2).
- AVG_LOG2, 3, log2 of samples per average (0..6).
- TIMEOUT, 4096, max clocks from fetch to reading before fault.

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous reset, active-high
- enable  in  1  run sampling; low = stop
- als_ready  in  1  reader idle / reading valid
- als_fetch  out  1  one-cycle request to reader
- als_illum  in  8  reader result, valid once als_ready returns high
- thr_dark  in  8  dark-entry threshold
- thr_light  in  8  dark-exit threshold (intended >= thr_dark)
- level  out  8  latest averaged illumination
- level_valid  out  1  one-cycle pulse when level updates
- dark  out  1  hysteresis classification
- changed  out  1  one-cycle pulse when dark toggles
- fault  out  1  sticky reader-timeout flag

Behaviour:
- Reset (async, high): state IDLE; all outputs 0; accumulator, sample count, tick counter and pending tick cleared.
- Tick generator: while enable=1, down-counter reloads SAMPLE_PERIOD-1 and emits a 1-cycle tick at 0. While enable=0 it is held at reload.
- A tick arriving outside WAIT sets a single pending flag. Extra ticks are dropped, not counted.
- FSM states:
  - IDLE: go to WAIT when enable=1.
  - WAIT: on (tick or pending) and als_ready=1, assert als_fetch for exactly one cycle, clear pending, go to BUSY. If als_ready=0, hold pending.
  - BUSY: seen_low flag sets when als_ready=0. On the first edge with als_ready=1 and seen_low=1, add als_illum to the accumulator, increment count and go to WAIT.
  - BUSY timeout: the timeout counter reaching TIMEOUT sets fault=1, discards the sample and returns to WAIT. Ready never dropping counts as timeout.
- Accumulator is 8+AVG_LOG2 bits and cannot overflow.
- Average: when count reaches 2^AVG_LOG2, on the next edge level = acc >> AVG_LOG2 (truncating), level_valid=1 for one cycle, acc and count cleared.
- Classification is evaluated on the edge after level_valid; dark and changed update on that edge:
  - level < thr_dark -> dark=1.
  - else level > thr_light -> dark=0.
  - else hold.
  - changed=1 for one cycle only if dark differs from its prior value.
  - Misordered thresholds (thr_light < thr_dark): the dark-entry test has priority.
- enable falling:
  - From WAIT or IDLE: go to IDLE next edge.
  - From BUSY: finish or time out the in-flight read first, because the reader cannot be aborted; the sample is then discarded.
  - Entering IDLE clears acc, count and pending. level and dark hold.
- fault clears on an enable 0->1 transition or on Reset.
- als_fetch is never asserted while als_ready=0, and never twice without an intervening BUSY.

Decomposition:
- als_pkg: FSM state encoding (IDLE, WAIT, BUSY), ILLUM_W=8, width helper for the accumulator and counters.
- Sub-module als_tick_gen: parameterised period counter with enable and tick output.

Test Plan:
Bench parameters: SAMPLE_PERIOD=16, AVG_LOG2=2, TIMEOUT=64. The reader model drops als_ready for 20 cycles after fetch.
- Reset mid-BUSY -> all outputs 0 immediately, als_fetch stays 0 until enable seen after release.
- Readings 10,20,30,41 with thresholds 50/80 -> level=25 (truncated), one level_valid pulse, dark=1 and changed=1 on the following edge.
- Averages 60 then 85 with dark=1 -> 60 holds dark=1 with no changed; 85 clears dark with one changed pulse.
- Reader model never drops ready -> fault=1 64 cycles after fetch, no accumulate; enable 0->1 clears fault.
- Reader busy for 40 cycles (longer than period) -> exactly one pending fetch issued right after ready returns; no double fetch.
- enable dropped during BUSY -> read completes, sample discarded, FSM reaches IDLE, level unchanged, next run needs 4 fresh samples.

Source files
------------

// File: rtl/als_pkg.sv
// -----------------------------------------------------------------------------
// als_pkg
// Shared definitions for the ambient-light monitor: sampler FSM state
// encoding, reader data width, and width helpers for the accumulator and
// counters.
// -----------------------------------------------------------------------------
package als_pkg;

   localparam int ILLUM_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_BUSY = 2'd2
   } als_state_t;

   // Bits needed to hold every value 0..max_val (at least one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   // Sum of 2^avg_log2 readings of ILLUM_W bits each fits without overflow.
   function automatic int acc_width(input int avg_log2);
      return ILLUM_W + avg_log2;
   endfunction

endpackage

// File: rtl/als_tick_gen.sv
// -----------------------------------------------------------------------------
// als_tick_gen
// Down-counter that emits a one-cycle tick every SAMPLE_PERIOD clocks while
// enabled, and sits at its reload value while disabled.
// Ports:
//   i_clk     system clock
//   i_rst     asynchronous reset, active-high
//   i_enable  run the counter; low holds it at reload
//   o_tick    one-cycle pulse when the count reaches zero
// -----------------------------------------------------------------------------
module als_tick_gen
   import als_pkg::*;
#(
   parameter int SAMPLE_PERIOD = 100000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_enable,
   output logic o_tick
);

   localparam int CW = cnt_width(SAMPLE_PERIOD - 1);
   localparam logic [CW-1:0] RELOAD = CW'(SAMPLE_PERIOD - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (!i_enable || (r_cnt == '0)) begin
         r_cnt <= RELOAD;
      end else begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_tick = i_enable & (r_cnt == '0);

endmodule

// File: rtl/als_monitor.sv
// -----------------------------------------------------------------------------
// als_monitor
// Periodic sampler and hysteresis classifier for the ambient-light sensor.
// Requests a reading from the SPI reader every SAMPLE_PERIOD clocks,
// block-averages 2^AVG_LOG2 readings and classifies the average as dark or
// light against two thresholds.
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous reset, active-high
//   i_enable       run sampling; low stops after any in-flight read
//   i_als_ready    reader idle / reading valid
//   o_als_fetch    one-cycle request to the reader
//   i_als_illum    reader result, valid once i_als_ready returns high
//   i_thr_dark     dark-entry threshold
//   i_thr_light    dark-exit threshold
//   o_level        latest averaged illumination
//   o_level_valid  one-cycle pulse when o_level updates
//   o_dark         hysteresis classification
//   o_changed      one-cycle pulse when o_dark toggles
//   o_fault        sticky reader-timeout flag
// -----------------------------------------------------------------------------
module als_monitor
   import als_pkg::*;
#(
   parameter int SAMPLE_PERIOD = 100000,
   parameter int AVG_LOG2      = 3,
   parameter int TIMEOUT       = 4096
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_enable,
   input  logic               i_als_ready,
   output logic               o_als_fetch,
   input  logic [ILLUM_W-1:0] i_als_illum,
   input  logic [ILLUM_W-1:0] i_thr_dark,
   input  logic [ILLUM_W-1:0] i_thr_light,
   output logic [ILLUM_W-1:0] o_level,
   output logic               o_level_valid,
   output logic               o_dark,
   output logic               o_changed,
   output logic               o_fault
);

   localparam int ACC_W = acc_width(AVG_LOG2);
   localparam int CNT_W = cnt_width(2 ** AVG_LOG2);
   localparam int TMO_W = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] FULL     = CNT_W'(2 ** AVG_LOG2);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   als_state_t       r_state;
   logic             r_pending;
   logic             r_seen_low;
   logic             r_drop;
   logic             r_en_d;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [TMO_W-1:0] r_tmo;

   logic w_tick;
   logic w_en_rise;
   logic w_done;
   logic w_timeout;
   logic w_abort;

   als_tick_gen #(
      .SAMPLE_PERIOD(SAMPLE_PERIOD)
   ) u_tick (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_enable (i_enable),
      .o_tick   (w_tick)
   );

   assign w_en_rise = i_enable & ~r_en_d;
   // A reading is only trusted once ready has been seen low after the fetch.
   assign w_done    = (r_state == ST_BUSY) & i_als_ready & r_seen_low;
   assign w_timeout = (r_state == ST_BUSY) & ~w_done & (r_tmo == TMO_LAST);
   // The reader cannot be aborted, so an enable drop during BUSY is latched
   // and acted on only when the read finishes or times out.
   assign w_abort   = r_drop | ~i_enable;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_pending     <= 1'b0;
         r_seen_low    <= 1'b0;
         r_drop        <= 1'b0;
         r_en_d        <= 1'b0;
         r_acc         <= '0;
         r_cnt         <= '0;
         r_tmo         <= '0;
         o_als_fetch   <= 1'b0;
         o_level       <= '0;
         o_level_valid <= 1'b0;
         o_dark        <= 1'b0;
         o_changed     <= 1'b0;
         o_fault       <= 1'b0;
      end else begin
         r_en_d        <= i_enable;
         o_als_fetch   <= 1'b0;
         o_level_valid <= 1'b0;
         o_changed     <= 1'b0;

         // Only one missed tick is remembered; further ticks are dropped.
         if (w_tick && (r_state != ST_WAIT)) r_pending <= 1'b1;
         if (w_en_rise) o_fault <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (i_enable) r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!i_enable) begin
                  r_state   <= ST_IDLE;
                  r_acc     <= '0;
                  r_cnt     <= '0;
                  r_pending <= 1'b0;
               end else if ((w_tick || r_pending) && i_als_ready) begin
                  o_als_fetch <= 1'b1;
                  r_pending   <= 1'b0;
                  r_seen_low  <= 1'b0;
                  r_drop      <= 1'b0;
                  r_tmo       <= '0;
                  r_state     <= ST_BUSY;
               end else if (w_tick) begin
                  r_pending <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (!i_enable)    r_drop     <= 1'b1;
               if (!i_als_ready) r_seen_low <= 1'b1;
               r_tmo <= r_tmo + TMO_W'(1);
               if (w_done || w_timeout) begin
                  if (w_timeout) o_fault <= 1'b1;
                  if (w_done && !w_abort) begin
                     r_acc <= r_acc + ACC_W'(i_als_illum);
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
                  if (w_abort) begin
                     r_state   <= ST_IDLE;
                     r_acc     <= '0;
                     r_cnt     <= '0;
                     r_pending <= 1'b0;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // Block average: the top ILLUM_W bits of the sum are sum >> AVG_LOG2.
         if (r_cnt == FULL) begin
            o_level       <= r_acc[ACC_W-1:AVG_LOG2];
            o_level_valid <= 1'b1;
            r_acc         <= '0;
            r_cnt         <= '0;
         end

         // Hysteresis on the freshly published level; dark entry wins when
         // the thresholds are misordered.
         if (o_level_valid) begin
            if (o_level < i_thr_dark) begin
               o_dark    <= 1'b1;
               o_changed <= ~o_dark;
            end else if (o_level > i_thr_light) begin
               o_dark    <= 1'b0;
               o_changed <= o_dark;
            end
         end
      end
   end

endmodule

// File: tb/tb_als_monitor.sv
// -----------------------------------------------------------------------------
// tb_als_monitor
// Directed scenario sequence plus randomized readings for als_monitor, with a
// reader model and a transaction-level reference for averages and hysteresis.
// -----------------------------------------------------------------------------
module tb_als_monitor;

   localparam int SP = 16;
   localparam int AL = 2;
   localparam int TO = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       als_ready = 1'b1;
   logic [7:0] als_illum = 8'd0;
   logic [7:0] thr_dark = 8'd50;
   logic [7:0] thr_light = 8'd80;
   logic       fetch;
   logic [7:0] level;
   logic       lvl_valid;
   logic       dark;
   logic       changed;
   logic       fault;

   always #5 clk = ~clk;

   als_monitor #(
      .SAMPLE_PERIOD(SP),
      .AVG_LOG2     (AL),
      .TIMEOUT      (TO)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_enable      (enable),
      .i_als_ready   (als_ready),
      .o_als_fetch   (fetch),
      .i_als_illum   (als_illum),
      .i_thr_dark    (thr_dark),
      .i_thr_light   (thr_light),
      .o_level       (level),
      .o_level_valid (lvl_valid),
      .o_dark        (dark),
      .o_changed     (changed),
      .o_fault       (fault)
   );

   int vec = 0;
   int err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- reader model and reference ----------------
   int  busy_len = 20;
   bit  nodrop = 1'b0;
   bit  rbusy = 1'b0;
   int  rcnt = 0;
   bit  rok = 1'b0;
   int  vq[$];
   int  accq[$];
   bit  m_dark = 1'b0;
   bit  pend_cls = 1'b0;
   bit  exp_dark = 1'b0;
   bit  exp_chg = 1'b0;
   bit  prev_fetch = 1'b0;
   int  cyc = 0;
   int  ret_cyc = 0;
   int  val;
   int  sum;
   int  avg;
   bit  nd;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         accq.delete();
         m_dark   = 1'b0;
         pend_cls = 1'b0;
      end
      if (fetch) begin
         chk("fetch_while_ready", als_ready, 1);
         chk("fetch_one_cycle", prev_fetch, 0);
      end
      prev_fetch = fetch;

      if (rbusy) begin
         if (rst || !enable) rok = 1'b0;
         rcnt--;
         if (rcnt == 0) begin
            rbusy = 1'b0;
            val = (vq.size() > 0) ? vq.pop_front() : int'($urandom_range(60, 200));
            als_illum = 8'(val);
            als_ready = 1'b1;
            ret_cyc = cyc;
            if (rok) accq.push_back(val);
         end
      end else if (fetch && !nodrop) begin
         rbusy = 1'b1;
         rcnt = busy_len;
         rok = enable && !rst;
         als_ready = 1'b0;
         als_illum = 8'($urandom);
      end

      if (pend_cls) begin
         chk("model_dark", dark, exp_dark);
         chk("model_changed", changed, exp_chg);
         pend_cls = 1'b0;
      end else begin
         chk("changed_quiet", changed, 0);
      end

      if (lvl_valid) begin
         if (accq.size() >= 4) begin
            sum = 0;
            repeat (4) sum += accq.pop_front();
            avg = sum / 4;
            chk("model_level", level, avg);
            if (avg < int'(thr_dark))       nd = 1'b1;
            else if (avg > int'(thr_light)) nd = 1'b0;
            else                            nd = m_dark;
            exp_chg  = (nd != m_dark);
            exp_dark = nd;
            m_dark   = nd;
            pend_cls = 1'b1;
         end else begin
            chk("spurious_valid", lvl_valid, 0);
         end
      end
   end

   // ---------------- bounded waits ----------------
   task automatic wait_fetch(input int budget, input string tag);
      bit got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         got = fetch;
      end
      chk(tag, got, 1);
   endtask

   task automatic wait_valid(input int budget, input string tag);
      bit got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         got = lvl_valid;
      end
      chk(tag, got, 1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int  n;
      int  cnt;
      bit  got;
      logic [7:0] saved;

      repeat (3) @(negedge clk);
      chk("rst_fetch", fetch, 0);
      chk("rst_level", level, 0);
      chk("rst_valid", lvl_valid, 0);
      chk("rst_dark", dark, 0);
      chk("rst_changed", changed, 0);
      chk("rst_fault", fault, 0);
      rst = 1'b0;
      @(negedge clk);

      // Averages 25, 60, 85 against thresholds 50/80.
      vq = '{10, 20, 30, 41, 60, 60, 60, 60, 85, 85, 85, 85};
      enable = 1'b1;
      wait_valid(400, "t25_valid");
      chk("t25_level", level, 25);
      @(negedge clk);
      chk("t25_dark", dark, 1);
      chk("t25_changed", changed, 1);
      chk("t25_pulse", lvl_valid, 0);

      wait_valid(400, "t60_valid");
      chk("t60_level", level, 60);
      @(negedge clk);
      chk("t60_dark", dark, 1);
      chk("t60_changed", changed, 0);

      wait_valid(400, "t85_valid");
      chk("t85_level", level, 85);
      @(negedge clk);
      chk("t85_dark", dark, 0);
      chk("t85_changed", changed, 1);

      // Random readings, ordered then misordered thresholds.
      thr_dark  = 8'($urandom_range(110, 130));
      thr_light = 8'(int'(thr_dark) + int'($urandom_range(0, 25)));
      repeat (6) begin
         wait_valid(400, "rnd_valid");
         @(negedge clk);
      end
      thr_dark  = 8'($urandom_range(125, 145));
      thr_light = 8'(int'(thr_dark) - int'($urandom_range(5, 25)));
      repeat (4) begin
         wait_valid(400, "mis_valid");
         @(negedge clk);
      end

      // Reader slower than the sample period: one pending fetch only.
      busy_len = 40;
      wait_fetch(100, "b40_fetch");
      @(negedge clk);
      busy_len = 2;
      wait_fetch(100, "b40_pending_fetch");
      chk("b40_pending_gap", cyc - ret_cyc, 2);
      cnt = 0;
      repeat (14) begin
         @(negedge clk);
         if (fetch) cnt++;
      end
      chk("b40_no_extra_fetch", (cnt <= 1), 1);
      @(negedge clk);
      busy_len = 20;

      // Enable dropped in BUSY: read completes, sample discarded.
      wait_fetch(100, "drop_fetch");
      repeat (3) @(negedge clk);
      enable = 1'b0;
      accq.delete();
      vq.push_back(200);
      saved = level;
      cnt = 0;
      repeat (60) begin
         @(negedge clk);
         if (fetch) cnt++;
      end
      chk("drop_no_fetch", cnt, 0);
      chk("drop_level_hold", level, saved);
      vq.push_back(100);
      vq.push_back(104);
      vq.push_back(108);
      vq.push_back(112);
      enable = 1'b1;
      wait_valid(400, "drop_valid");
      chk("drop_fresh_avg", level, 106);

      // Reader never drops ready: timeout fault.
      @(negedge clk);
      nodrop = 1'b1;
      wait_fetch(100, "to_fetch");
      chk("to_fault_pre", fault, 0);
      n = 0;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         n++;
         got = fault;
      end
      chk("to_fault_seen", got, 1);
      chk("to_latency", n, TO);
      enable = 1'b0;
      accq.delete();
      repeat (80) @(negedge clk);
      chk("to_fault_sticky", fault, 1);
      nodrop = 1'b0;
      enable = 1'b1;
      @(negedge clk);
      chk("to_fault_clear", fault, 0);

      // Reset in the middle of a read.
      wait_fetch(100, "rb_fetch");
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b1;
      enable = 1'b0;
      #1;
      chk("rb_fetch0", fetch, 0);
      chk("rb_level0", level, 0);
      chk("rb_valid0", lvl_valid, 0);
      chk("rb_dark0", dark, 0);
      chk("rb_changed0", changed, 0);
      chk("rb_fault0", fault, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (fetch) cnt++;
      end
      chk("rb_no_fetch", cnt, 0);
      enable = 1'b1;
      wait_fetch(100, "rb_refetch");
      wait_valid(400, "rb_valid");
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
